// File: rtl/seq_pattern_pkg.sv
// rtl/seq_pattern_pkg.sv - control codes, FSM state encoding and default pattern for seq_pattern_player
//
// Contents:
//   CODE_START(w), CODE_STOP(), CODE_PAUSE(w) : control words for a w-bit datapath (w <= MAX_DATA_W)
//   state_e                                  : playback FSM states
//   init_word(idx, w)                        : default pattern table (START, START, PAUSE, START, STOP, STOP...)
package seq_pattern_pkg;

    // Codes are built at the widest supported width and truncated by the user.
    localparam int MAX_DATA_W = 64;

    typedef logic [MAX_DATA_W-1:0] word_max_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    function automatic word_max_t CODE_START(int data_w);
        return ~word_max_t'(0) >> (MAX_DATA_W - data_w);
    endfunction

    function automatic word_max_t CODE_STOP();
        return '0;
    endfunction

    // All ones shifted right by half the word: the low data_w/2 bits set.
    function automatic word_max_t CODE_PAUSE(int data_w);
        return ~word_max_t'(0) >> (MAX_DATA_W - data_w / 2);
    endfunction

    function automatic word_max_t init_word(int idx, int data_w);
        case (idx)
            0, 1, 3: return CODE_START(data_w);
            2:       return CODE_PAUSE(data_w);
            default: return CODE_STOP();
        endcase
    endfunction

endpackage

// File: rtl/seq_pattern_player_if.sv
// rtl/seq_pattern_player_if.sv - command word valid/ready stream between player and actuator driver
//
// Signals:
//   cmd_valid : producer -> consumer, cmd_data is valid
//   cmd_data  : producer -> consumer, DATA_W command word
//   cmd_ready : consumer -> producer, word accepted when high with cmd_valid
// Modports: master (player side), slave (consumer side)
interface seq_pattern_player_if #(
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/seq_pattern_mem.sv
// rtl/seq_pattern_mem.sv - pattern RAM, one write port and one registered read port, read-before-write
//
// Ports:
//   clk      in  clock, rising edge
//   wr_en    in  write strobe; addresses >= DEPTH are dropped
//   wr_addr  in  ADDR_W write address
//   wr_data  in  DATA_W write data
//   rd_en    in  load rd_data from mem[rd_addr]
//   rd_addr  in  ADDR_W read address (must be < DEPTH)
//   rd_data  out DATA_W registered read word; same-address write in the same cycle returns old data
// Build option: SEQ_PATTERN_PLAYER_INIT_EN preloads the default pattern table from seq_pattern_pkg.
module seq_pattern_mem
    import seq_pattern_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

`ifdef SEQ_PATTERN_PLAYER_INIT_EN
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = DATA_W'(init_word(i, DATA_W));
        end
        return m;
    endfunction

    mem_t mem = init_mem();
`else
    logic [DATA_W-1:0] mem [DEPTH];
`endif

    logic wr_in_range;

    // When DEPTH fills the address space every address is legal.
    generate
        if (DEPTH < (1 << ADDR_W)) begin : g_partial
            assign wr_in_range = (wr_addr < ADDR_W'(DEPTH));
        end else begin : g_full
            assign wr_in_range = 1'b1;
        end
    endgenerate

    // Both ports in one block with non-blocking updates gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/seq_pattern_player.sv
// rtl/seq_pattern_player.sv - writable pattern memory with address-range playback sequencer
//
// Ports:
//   pulse      in  clock, rising edge
//   rst        in  asynchronous active-high reset
//   wr_en/wr_addr/wr_data  in  pattern memory write port (any state)
//   start      in  begin playback (IDLE only; wins over stop_req)
//   stop_req   in  abort playback, withdraws cmd_valid
//   loop_en    in  wrap last_addr -> base_addr, sampled at each advance
//   base_addr  in  first playback address, captured at start
//   last_addr  in  final playback address, captured at start
//   cmd        master modport of seq_pattern_player_if (cmd_valid, cmd_data, cmd_ready)
//   busy       out playback in progress
//   done       out one-cycle pulse at playback end
//   cur_addr   out address being fetched
// Build option: SEQ_PATTERN_PLAYER_INIT_EN preloads the default pattern (see seq_pattern_mem).
module seq_pattern_player
    import seq_pattern_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int PAUSE_CYCLES = 16
) (
    input  logic                  pulse,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  start,
    input  logic                  stop_req,
    input  logic                  loop_en,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     last_addr,
    seq_pattern_player_if.master  cmd,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     cur_addr
);

    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [DATA_W-1:0] WORD_STOP  = DATA_W'(CODE_STOP());
    localparam logic [DATA_W-1:0] WORD_PAUSE = DATA_W'(CODE_PAUSE(DATA_W));
    localparam logic [ADDR_W-1:0] ADDR_END   = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(PAUSE_CYCLES - 1);

    state_e            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] last_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] word;

    state_e            adv_state;
    logic [ADDR_W-1:0] adv_addr;

    seq_pattern_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (pulse),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state == ST_FETCH),
        .rd_addr (cur_addr),
        .rd_data (word)
    );

    // Where the sequencer goes after a word has been consumed (emitted or paused on).
    always_comb begin
        adv_state = ST_FETCH;
        adv_addr  = cur_addr;
        if (cur_addr == last_q) begin
            if (loop_en) begin
                adv_addr = base_q;
            end else begin
                adv_state = ST_DONE;
            end
        end else if (cur_addr == ADDR_END) begin
            adv_addr = '0;
        end else begin
            adv_addr = cur_addr + 1'b1;
        end
    end

    always_comb begin
        busy = (state == ST_FETCH) || (state == ST_DECODE) ||
               (state == ST_EMIT)  || (state == ST_HOLD);
        done = (state == ST_DONE);
    end

    always_ff @(posedge pulse or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cur_addr      <= '0;
            base_q        <= '0;
            last_q        <= '0;
            cnt           <= '0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_data  <= '0;
        end else if (busy && stop_req) begin
            // Abort beats a same-cycle handshake: the word is treated as not taken.
            state         <= ST_DONE;
            cmd.cmd_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        last_q   <= last_addr;
                        cur_addr <= base_addr;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (word == WORD_STOP) begin
                        state <= ST_DONE;
                    end else if (word == WORD_PAUSE) begin
                        cnt   <= CNT_LOAD;
                        state <= ST_HOLD;
                    end else begin
                        cmd.cmd_data  <= word;
                        cmd.cmd_valid <= 1'b1;
                        state         <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (cmd.cmd_ready) begin
                        cmd.cmd_valid <= 1'b0;
                        cur_addr      <= adv_addr;
                        state         <= adv_state;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        cur_addr <= adv_addr;
                        state    <= adv_state;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_player.sv
// tb/tb_seq_pattern_player.sv - scoreboard testbench for seq_pattern_player
module tb_seq_pattern_player;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int DEPTH        = 1024;
    localparam int PAUSE_CYCLES = 16;

    logic              pulse = 1'b0;
    logic              rst   = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic              stop_req = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] cur_addr;

    seq_pattern_player_if #(.DATA_W(DATA_W)) cmd_if ();

    seq_pattern_player #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .PAUSE_CYCLES (PAUSE_CYCLES)
    ) dut (
        .pulse     (pulse),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop_req  (stop_req),
        .loop_en   (loop_en),
        .base_addr (base_addr),
        .last_addr (last_addr),
        .cmd       (cmd_if.master),
        .busy      (busy),
        .done      (done),
        .cur_addr  (cur_addr)
    );

    always #5 pulse = ~pulse;

    int cyc = 0;
    always @(posedge pulse) cyc = cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                hs_count = 0;
    int                hs_cyc[$];
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge; a handshake completes at the next rising edge.
    always @(negedge pulse) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("valid_hold", 64'(cmd_if.cmd_valid), 64'd1);
                check("data_hold", 64'(cmd_if.cmd_data), 64'(prev_data));
            end
            if (cmd_if.cmd_valid && cmd_if.cmd_ready && !stop_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handshake", 64'(cmd_if.cmd_data), 64'hx);
                end else begin
                    check("cmd_data", 64'(cmd_if.cmd_data), 64'(exp_q.pop_front()));
                end
                hs_count = hs_count + 1;
                hs_cyc.push_back(cyc);
            end
            prev_stall = cmd_if.cmd_valid && !cmd_if.cmd_ready && !stop_req;
            prev_data  = cmd_if.cmd_data;
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge pulse);
            #2;
        end
    endtask

    task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic go(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
        base_addr = b;
        last_addr = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic wait_hs(input string name, input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(hs_count), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int c0;
        cmd_if.cmd_ready = 1'b0;

        // Reset state
        step(2);
        check("rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
        check("rst_data", 64'(cmd_if.cmd_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cur_addr", 64'(cur_addr), 64'd0);
        rst = 1'b0;
        step();

        // 1: two data words then STOP
        mem_write(10'd0, 32'hA5A5A5A5);
        mem_write(10'd1, 32'hFFFFFFFF);
        mem_write(10'd2, 32'h00000000);
        exp_q.push_back(32'hA5A5A5A5);
        exp_q.push_back(32'hFFFFFFFF);
        cmd_if.cmd_ready = 1'b1;
        h0 = hs_count;
        go(10'd0, 10'd5);
        wait_done("t1_done", 100);
        check("t1_busy_at_done", 64'(busy), 64'd0);
        check("t1_handshakes", 64'(hs_count - h0), 64'd2);
        step();
        check("t1_idle_busy", 64'(busy), 64'd0);
        check("t1_done_one_cycle", 64'(done), 64'd0);

        // 2: PAUSE between two words; accepted 3 + 2 + PAUSE_CYCLES cycles apart
        mem_write(10'd0, 32'h12345678);
        mem_write(10'd1, 32'h0000FFFF);
        mem_write(10'd2, 32'h87654321);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h87654321);
        h0 = hs_count;
        c0 = hs_cyc.size();
        go(10'd0, 10'd2);
        step(10);
        check("t2_hold_cur_addr", 64'(cur_addr), 64'd1);
        check("t2_hold_busy", 64'(busy), 64'd1);
        check("t2_hold_valid", 64'(cmd_if.cmd_valid), 64'd0);
        wait_done("t2_done", 100);
        check("t2_handshakes", 64'(hs_count - h0), 64'd2);
        if (hs_cyc.size() >= c0 + 2) begin
            check("t2_gap", 64'(hs_cyc[c0+1] - hs_cyc[c0]), 64'(3 + 2 + PAUSE_CYCLES));
        end else begin
            check("t2_gap_samples", 64'(hs_cyc.size() - c0), 64'd2);
        end
        step();

        // 3: backpressure holds the word stable
        mem_write(10'd0, 32'hCAFEBABE);
        mem_write(10'd1, 32'h00000000);
        exp_q.push_back(32'hCAFEBABE);
        cmd_if.cmd_ready = 1'b0;
        h0 = hs_count;
        go(10'd0, 10'd5);
        step(12);
        check("t3_stalled_hs", 64'(hs_count - h0), 64'd0);
        check("t3_stalled_valid", 64'(cmd_if.cmd_valid), 64'd1);
        check("t3_stalled_data", 64'(cmd_if.cmd_data), 64'hCAFEBABE);
        cmd_if.cmd_ready = 1'b1;
        wait_done("t3_done", 50);
        check("t3_handshakes", 64'(hs_count - h0), 64'd1);
        step();

        // 4: looping 4..5, then drop loop_en
        mem_write(10'd4, 32'h11111111);
        mem_write(10'd5, 32'h22222222);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h11111111);
            exp_q.push_back(32'h22222222);
        end
        loop_en = 1'b1;
        h0 = hs_count;
        go(10'd4, 10'd5);
        wait_hs("t4_five_words", h0 + 5, 100);
        loop_en = 1'b0;
        wait_done("t4_done", 50);
        check("t4_handshakes", 64'(hs_count - h0), 64'd6);
        step();

        // 5: stop_req during EMIT with ready high: no handshake
        mem_write(10'd0, 32'hDEADBEEF);
        mem_write(10'd1, 32'hDEADBEEF);
        cmd_if.cmd_ready = 1'b0;
        h0 = hs_count;
        go(10'd0, 10'd5);
        step(3);
        check("t5_emit_valid", 64'(cmd_if.cmd_valid), 64'd1);
        stop_req = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        step();
        stop_req = 1'b0;
        check("t5_valid_cleared", 64'(cmd_if.cmd_valid), 64'd0);
        check("t5_done", 64'(done), 64'd1);
        check("t5_no_handshake", 64'(hs_count - h0), 64'd0);
        step();

        // 6: reset in the middle of a HOLD; memory survives
        mem_write(10'd1, 32'h0000FFFF);
        mem_write(10'd2, 32'h00000000);
        go(10'd1, 10'd2);
        step(6);
        check("t6_hold_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
        check("t6_rst_data", 64'(cmd_if.cmd_data), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_cur_addr", 64'(cur_addr), 64'd0);
        step();
        rst = 1'b0;
        step();
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h22222222);
        h0 = hs_count;
        go(10'd4, 10'd5);
        wait_done("t6_retain_done", 50);
        check("t6_retain_handshakes", 64'(hs_count - h0), 64'd2);
        step();

        // 7: write to cur_addr during FETCH returns old word, new word next pass
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'h33333333);
        loop_en = 1'b1;
        h0 = hs_count;
        go(10'd4, 10'd4);
        wr_en   = 1'b1;
        wr_addr = 10'd4;
        wr_data = 32'h33333333;
        step();
        wr_en   = 1'b0;
        wait_hs("t7_first_word", h0 + 1, 50);
        loop_en = 1'b0;
        wait_done("t7_done", 50);
        check("t7_handshakes", 64'(hs_count - h0), 64'd2);
        step(2);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
